// File: rtl/pov_column_fetch_if.sv
// Bus bundle between the column fetch stage, the angle generator,
// the texture ROM and the WS2812 strip controller.
interface pov_column_fetch_if #(
  parameter int LED_COUNT  = 52,
  parameter int TEX_WIDTH  = 256,
  parameter int THETA_BITS = 6,
  parameter int PX_BITS    = 6,
  parameter int ADDR_BITS  = $clog2(TEX_WIDTH * LED_COUNT)
);
  localparam int COL_BITS = $clog2(TEX_WIDTH);

  logic [THETA_BITS-1:0] theta;
  logic [7:0]            brightness;
  logic [PX_BITS-1:0]    next_px_num;
  logic [ADDR_BITS-1:0]  rom_addr;
  logic [23:0]           rom_data;
  logic [23:0]           pixel;
  logic [COL_BITS-1:0]   frame_col;
  logic                  buf_ready;
  logic                  underrun;

  // Environment side: angle source, ROM and strip controller
  modport master (
    output theta, brightness, next_px_num, rom_data,
    input  rom_addr, pixel, frame_col, buf_ready, underrun
  );

  // Column fetch stage
  modport slave (
    input  theta, brightness, next_px_num, rom_data,
    output rom_addr, pixel, frame_col, buf_ready, underrun
  );
endinterface

// File: rtl/pov_column_fetch.sv
// Column fetch stage: at each strip frame start, latch the angle, convert it
// to a texture column and fill the back half of a ping-pong column store from
// ROM; the strip controller reads the front half brightness-scaled.
module pov_column_fetch #(
  parameter int LED_COUNT  = 52,
  parameter int TEX_WIDTH  = 256,
  parameter int THETA_BITS = 6,
  parameter int PX_BITS    = 6,
  parameter int ADDR_BITS  = $clog2(TEX_WIDTH * LED_COUNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  pov_column_fetch_if.slave  bus
);
  localparam int COL_BITS  = $clog2(TEX_WIDTH);
  localparam int ROW_BITS  = $clog2(LED_COUNT + 1);
  localparam int PROD_BITS = THETA_BITS + COL_BITS;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e                state_q, state_d;
  logic [PX_BITS-1:0]    prev_px_q, prev_px_d;
  logic [COL_BITS-1:0]   fill_col_q, fill_col_d;
  logic [COL_BITS-1:0]   frame_col_q, frame_col_d;
  logic [7:0]            fill_bri_q, fill_bri_d;
  logic [7:0]            front_bri_q, front_bri_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic                  vld_p1_q, vld_p1_d;
  logic [ROW_BITS-1:0]   row_p1_q, row_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic [ROW_BITS-1:0]   row_p2_q, row_p2_d;
  logic [ADDR_BITS-1:0]  rom_addr_q, rom_addr_d;
  logic                  front_sel_q, front_sel_d;
  logic                  front_valid_q, front_valid_d;
  logic                  underrun_q, underrun_d;
  logic [23:0]           pixel_q, pixel_d;
  logic [23:0]           col_buf_q [2][LED_COUNT];

  logic                  frame_start;
  logic                  last_wr;
  logic                  do_swap;
  logic [COL_BITS-1:0]   col_new;

  // Per-channel brightness scale: c * (bri + 1) / 256, so bri = 255 is identity
  function automatic logic [23:0] scale_px(input logic [23:0] px, input logic [7:0] bri);
    logic [15:0] mult;
    logic [23:0] res;
    mult = 16'({1'b0, bri}) + 16'd1;
    res  = '0;
    for (int ch = 0; ch < 3; ch++) begin
      res[8*ch +: 8] = 8'((16'(px[8*ch +: 8]) * mult) >> 8);
    end
    return res;
  endfunction

  assign frame_start = (bus.next_px_num == '0) && (prev_px_q != '0);
  assign col_new     = COL_BITS'((PROD_BITS'(bus.theta) * PROD_BITS'(TEX_WIDTH)) >> THETA_BITS);
  assign last_wr     = vld_p2_q && (row_p2_q == ROW_BITS'(LED_COUNT - 1));
  assign do_swap     = frame_start && ((state_q == DONE) || ((state_q == FILL) && last_wr));

  // State register plus all datapath flops; buffer store has no reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prev_px_q     <= '1;
      frame_col_q   <= '0;
      row_q         <= '0;
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      rom_addr_q    <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      pixel_q       <= '0;
    end else begin
      state_q       <= state_d;
      prev_px_q     <= prev_px_d;
      frame_col_q   <= frame_col_d;
      row_q         <= row_d;
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      rom_addr_q    <= rom_addr_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      underrun_q    <= underrun_d;
      pixel_q       <= pixel_d;
    end
    fill_col_q  <= fill_col_d;
    fill_bri_q  <= fill_bri_d;
    front_bri_q <= front_bri_d;
    row_p1_q    <= row_p1_d;
    row_p2_q    <= row_p2_d;
    if (vld_p2_q) begin
      col_buf_q[~front_sel_q][row_p2_q] <= bus.rom_data;
    end
  end

  // Next-state logic: any frame start (re)starts a fill
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = FILL;
      FILL:    if (frame_start) state_d = FILL;
               else if (last_wr) state_d = DONE;
      DONE:    if (frame_start) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // Fill sequencing, swap/underrun handling and the pixel read path
  always_comb begin
    prev_px_d     = bus.next_px_num;
    fill_col_d    = fill_col_q;
    fill_bri_d    = fill_bri_q;
    frame_col_d   = frame_col_q;
    front_bri_d   = front_bri_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    underrun_d    = underrun_q;
    row_d         = row_q;
    rom_addr_d    = rom_addr_q;
    // p0 -> p1: ROM address issue, row tag travels with it
    vld_p1_d      = 1'b0;
    row_p1_d      = row_p1_q;
    // p1 -> p2: ROM data now valid, written to the back buffer next edge
    vld_p2_d      = vld_p1_q;
    row_p2_d      = row_p1_q;

    if (frame_start) begin
      fill_col_d = col_new;
      fill_bri_d = bus.brightness;
      rom_addr_d = ADDR_BITS'(col_new);
      vld_p1_d   = 1'b1;
      row_p1_d   = '0;
      row_d      = ROW_BITS'(1);
      vld_p2_d   = 1'b0;
      if (do_swap) begin
        front_sel_d   = ~front_sel_q;
        front_valid_d = 1'b1;
        frame_col_d   = fill_col_q;
        front_bri_d   = fill_bri_q;
      end else if (state_q == FILL) begin
        underrun_d = 1'b1;
      end
    end else if ((state_q == FILL) && (row_q < ROW_BITS'(LED_COUNT))) begin
      rom_addr_d = ADDR_BITS'(row_q) * ADDR_BITS'(TEX_WIDTH) + ADDR_BITS'(fill_col_q);
      vld_p1_d   = 1'b1;
      row_p1_d   = row_q;
      row_d      = row_q + 1'b1;
    end

    if (front_valid_q && (bus.next_px_num < PX_BITS'(LED_COUNT))) begin
      pixel_d = scale_px(col_buf_q[front_sel_q][bus.next_px_num], front_bri_q);
    end else begin
      pixel_d = '0;
    end
  end

  // Output decode
  always_comb begin
    bus.buf_ready = (state_q == DONE);
    bus.rom_addr  = rom_addr_q;
    bus.pixel     = pixel_q;
    bus.frame_col = frame_col_q;
    bus.underrun  = underrun_q;
  end
endmodule

// File: tb/tb_pov_column_fetch.sv
// Directed bench for pov_column_fetch: reset, fill addressing, swap/read,
// brightness scaling, underrun, tear-free column change and reset mid-fill.
module tb_pov_column_fetch;
  localparam int LED_COUNT  = 52;
  localparam int TEX_WIDTH  = 256;
  localparam int THETA_BITS = 6;
  localparam int PX_BITS    = 6;
  localparam int ADDR_BITS  = 14;

  logic clk = 1'b0;
  logic rst_n;
  logic rom_mode;
  int   n_checks = 0;
  int   n_err    = 0;

  pov_column_fetch_if #(
    .LED_COUNT(LED_COUNT), .TEX_WIDTH(TEX_WIDTH), .THETA_BITS(THETA_BITS),
    .PX_BITS(PX_BITS), .ADDR_BITS(ADDR_BITS)
  ) bus ();

  pov_column_fetch #(
    .LED_COUNT(LED_COUNT), .TEX_WIDTH(TEX_WIDTH), .THETA_BITS(THETA_BITS),
    .PX_BITS(PX_BITS), .ADDR_BITS(ADDR_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM model: one-cycle read latency; mode 0 returns the address, mode 1 a fixed word
  always_ff @(posedge clk) begin
    bus.rom_data <= rom_mode ? 24'hFF8040 : 24'(bus.rom_addr);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max_cyc);
    int n;
    n = 0;
    while ((bus.buf_ready !== 1'b1) && (n < max_cyc)) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(bus.buf_ready), 32'd1);
  endtask

  initial begin
    rst_n           = 1'b0;
    rom_mode        = 1'b0;
    bus.theta       = 6'd16;
    bus.brightness  = 8'd255;
    bus.next_px_num = 6'd63;

    // Reset
    repeat (3) step();
    chk("rst_pixel",     32'(bus.pixel),     32'd0);
    chk("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
    chk("rst_buf_ready", 32'(bus.buf_ready), 32'd0);
    chk("rst_underrun",  32'(bus.underrun),  32'd0);
    chk("rst_frame_col", 32'(bus.frame_col), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Fill of column 64 (theta 16), one row address per cycle
    bus.next_px_num = 6'd0;
    for (int r = 0; r < LED_COUNT; r++) begin
      step();
      chk($sformatf("fill_addr_r%0d", r), 32'(bus.rom_addr), 32'(r * 256 + 64));
    end
    step();
    chk("fill_not_ready", 32'(bus.buf_ready), 32'd0);
    step();
    chk("fill_ready",     32'(bus.buf_ready), 32'd1);
    chk("fill_addr_hold", 32'(bus.rom_addr),  32'd13120);
    chk("pixel_no_front", 32'(bus.pixel),     32'd0);

    // Swap and read back
    bus.next_px_num = 6'd5;
    step();
    bus.next_px_num = 6'd0;
    step();
    chk("swap_frame_col", 32'(bus.frame_col), 32'd64);
    chk("swap_ready_clr", 32'(bus.buf_ready), 32'd0);
    chk("swap_refill",    32'(bus.rom_addr),  32'd64);
    bus.next_px_num = 6'd5;
    step();
    chk("pixel_px5",   32'(bus.pixel), 32'h000540);
    bus.next_px_num = 6'd55;
    step();
    chk("pixel_oob",   32'(bus.pixel), 32'd0);
    bus.next_px_num = 6'd51;
    step();
    chk("pixel_px51",  32'(bus.pixel), 32'h003340);

    // Underrun: frame start 20 cycles after the previous one
    bus.next_px_num = 6'd5;
    repeat (16) step();
    bus.next_px_num = 6'd0;
    step();
    chk("ur_flag",      32'(bus.underrun),  32'd1);
    chk("ur_addr_r0",   32'(bus.rom_addr),  32'd64);
    chk("ur_frame_col", 32'(bus.frame_col), 32'd64);
    chk("ur_not_ready", 32'(bus.buf_ready), 32'd0);
    rom_mode        = 1'b1;
    bus.next_px_num = 6'd5;
    step();
    chk("ur_pixel_kept", 32'(bus.pixel), 32'h000540);

    // Tear-free: theta and brightness change mid-frame
    bus.theta       = 6'd32;
    bus.brightness  = 8'd127;
    bus.next_px_num = 6'd10;
    step();
    chk("tf_pixel_px10",  32'(bus.pixel),     32'h000A40);
    chk("tf_addr_oldcol", 32'(bus.rom_addr),  32'd576);
    chk("tf_frame_col",   32'(bus.frame_col), 32'd64);
    wait_ready(80);
    bus.next_px_num = 6'd0;
    step();
    chk("tf_swap_col64",  32'(bus.frame_col), 32'd64);
    chk("tf_addr_col128", 32'(bus.rom_addr),  32'd128);
    chk("tf_ready_clr",   32'(bus.buf_ready), 32'd0);
    chk("ur_sticky",      32'(bus.underrun),  32'd1);
    bus.next_px_num = 6'd10;
    step();
    chk("bri255_word",    32'(bus.pixel),     32'hFF8040);
    chk("tf_addr_r1",     32'(bus.rom_addr),  32'd384);
    step();
    chk("tf_addr_r2",     32'(bus.rom_addr),  32'd640);
    wait_ready(80);
    bus.next_px_num = 6'd0;
    step();
    chk("tf_swap_col128", 32'(bus.frame_col), 32'd128);
    bus.next_px_num = 6'd10;
    step();
    chk("bri127_word",    32'(bus.pixel),     32'h7F4020);

    // Reset in the middle of a fill
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("mrst_pixel",     32'(bus.pixel),     32'd0);
    chk("mrst_rom_addr",  32'(bus.rom_addr),  32'd0);
    chk("mrst_frame_col", 32'(bus.frame_col), 32'd0);
    chk("mrst_underrun",  32'(bus.underrun),  32'd0);
    chk("mrst_ready",     32'(bus.buf_ready), 32'd0);
    rst_n           = 1'b1;
    bus.next_px_num = 6'd7;
    step();
    bus.next_px_num = 6'd0;
    step();
    chk("mrst_refill_r0", 32'(bus.rom_addr),  32'd128);
    bus.next_px_num = 6'd3;
    step();
    chk("mrst_no_front",  32'(bus.pixel),     32'd0);
    chk("mrst_addr_r1",   32'(bus.rom_addr),  32'd384);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
